// File: rtl/fip_pkg.sv
// Shared fixed-point types and constants for the Q16.16 ray-triangle datapath.
package fip_pkg;

    localparam int unsigned FRA_BITS  = 16;
    localparam int unsigned DIV_STEPS = 48;

    typedef logic signed [31:0] fip_t;

    localparam fip_t FIP_MIN = 32'sh80000000;
    localparam fip_t FIP_MAX = 32'sh7FFFFFFF;
    localparam fip_t FIP_ONE = 32'sh00010000;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StFin,
        StDone
    } cramer_state_e;

    // The 33-bit intermediate keeps |-2^31| = 2^31 exact; it still fits 32 unsigned bits.
    function automatic logic [31:0] fip_abs(input fip_t v);
        logic [32:0] ext;
        ext = {v[31], v};
        return 32'(v[31] ? (~ext + 33'd1) : ext);
    endfunction

endpackage

// File: rtl/fip_32_div_iter.sv
// Bit-serial restoring divider: (|num| << FRA_BITS) / |den| with sign and Q16.16 saturation.
module fip_32_div_iter
    import fip_pkg::*;
#(
    parameter int unsigned FRA_BITS = fip_pkg::FRA_BITS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic step,
    input  fip_t numerator,
    input  fip_t denominator,
    output fip_t quotient
);

    logic [47:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] den_q, den_d;
    logic        neg_q, neg_d;
    logic [31:0] num_mag;
    logic [32:0] shifted;

    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        den_d   = den_q;
        neg_d   = neg_q;
        num_mag = fip_abs(numerator);
        shifted = {rem_q, quo_q[47]};
        if (start) begin
            quo_d = {16'd0, num_mag} << FRA_BITS;
            rem_d = '0;
            den_d = fip_abs(denominator);
            neg_d = numerator[31] ^ denominator[31];
        end else if (step) begin
            if (shifted >= {1'b0, den_q}) begin
                rem_d = 32'(shifted - {1'b0, den_q});
                quo_d = {quo_q[46:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[46:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            neg_q <= 1'b0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            den_q <= den_d;
            neg_q <= neg_d;
        end
    end

    always_comb begin
        if (!neg_q) begin
            quotient = (quo_q > 48'h0000_7FFF_FFFF) ? FIP_MAX : fip_t'(quo_q[31:0]);
        end else if (quo_q > 48'h0000_8000_0000) begin
            quotient = FIP_MIN;
        end else begin
            quotient = fip_t'(~quo_q[31:0] + 32'd1);
        end
    end

endmodule

// File: rtl/fip_32_cramer_solve.sv
// Cramer's-rule back end: beta, gamma and t from four determinants, plus the hit decision.
module fip_32_cramer_solve
    import fip_pkg::*;
#(
    parameter int unsigned FRA_BITS = fip_pkg::FRA_BITS,
    parameter fip_t        T_MIN    = 32'sh00000041,
    parameter fip_t        DET_EPS  = 32'sh00000001
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_det_a,
    input  logic [31:0] i_det_b,
    input  logic [31:0] i_det_g,
    input  logic [31:0] i_det_t,
    input  logic [31:0] i_tmax,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_beta,
    output logic [31:0] o_gamma,
    output logic [31:0] o_t,
    output logic        o_hit,
    output logic        o_degen
);

    localparam logic signed [32:0] OneExt = {FIP_ONE[31], FIP_ONE};

    cramer_state_e state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          load_q, load_d;
    logic          step;
    logic          fin;
    logic          accept;

    fip_t det_a_q, det_b_q, det_g_q, det_t_q, tmax_q;
    logic degen_q;
    logic [31:0] abs_a;

    fip_t q_beta, q_gamma, q_t;
    logic signed [32:0] bg_sum;
    logic hit;

    fip_t beta_q, gamma_q, t_q;
    logic hit_q, degen_out_q;

    assign accept = (state_q == StIdle) && i_valid;
    assign abs_a  = fip_abs(fip_t'(i_det_a));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StDiv;
                    cnt_d   = 6'(DIV_STEPS - 1);
                    load_d  = 1'b1;
                end
            end
            StDiv: begin
                // The first DIV cycle loads the dividers from the captured operands.
                if (!load_q) begin
                    step = 1'b1;
                    if (cnt_q == 6'd0) begin
                        state_d = StFin;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            StFin: begin
                fin     = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            det_a_q <= '0;
            det_b_q <= '0;
            det_g_q <= '0;
            det_t_q <= '0;
            tmax_q  <= '0;
            degen_q <= 1'b0;
        end else if (accept) begin
            det_a_q <= fip_t'(i_det_a);
            det_b_q <= fip_t'(i_det_b);
            det_g_q <= fip_t'(i_det_g);
            det_t_q <= fip_t'(i_det_t);
            tmax_q  <= fip_t'(i_tmax);
            degen_q <= abs_a < DET_EPS;
        end
    end

    fip_32_div_iter #(.FRA_BITS(FRA_BITS)) u_div_beta (
        .clk        (i_clk),
        .rst_n      (i_rstn),
        .start      (load_q),
        .step       (step),
        .numerator  (det_b_q),
        .denominator(det_a_q),
        .quotient   (q_beta)
    );

    fip_32_div_iter #(.FRA_BITS(FRA_BITS)) u_div_gamma (
        .clk        (i_clk),
        .rst_n      (i_rstn),
        .start      (load_q),
        .step       (step),
        .numerator  (det_g_q),
        .denominator(det_a_q),
        .quotient   (q_gamma)
    );

    fip_32_div_iter #(.FRA_BITS(FRA_BITS)) u_div_t (
        .clk        (i_clk),
        .rst_n      (i_rstn),
        .start      (load_q),
        .step       (step),
        .numerator  (det_t_q),
        .denominator(det_a_q),
        .quotient   (q_t)
    );

    always_comb begin
        bg_sum = {q_beta[31], q_beta} + {q_gamma[31], q_gamma};
        hit    = !degen_q && !q_beta[31] && !q_gamma[31] && (bg_sum <= OneExt)
                 && (q_t > T_MIN) && (q_t < tmax_q);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            beta_q      <= '0;
            gamma_q     <= '0;
            t_q         <= '0;
            hit_q       <= 1'b0;
            degen_out_q <= 1'b0;
        end else if (fin) begin
            beta_q      <= degen_q ? '0 : q_beta;
            gamma_q     <= degen_q ? '0 : q_gamma;
            t_q         <= degen_q ? '0 : q_t;
            hit_q       <= hit;
            degen_out_q <= degen_q;
        end
    end

    assign o_ready = (state_q == StIdle);
    assign o_valid = (state_q == StDone);
    assign o_beta  = beta_q;
    assign o_gamma = gamma_q;
    assign o_t     = t_q;
    assign o_hit   = hit_q;
    assign o_degen = degen_out_q;

endmodule

// File: tb/tb_fip_32_cramer_solve.sv
// Directed bench for fip_32_cramer_solve: latency, signs, saturation, hit edges, backpressure, reset.
module tb_fip_32_cramer_solve;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_det_a = '0;
    logic [31:0] i_det_b = '0;
    logic [31:0] i_det_g = '0;
    logic [31:0] i_det_t = '0;
    logic [31:0] i_tmax = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_beta;
    logic [31:0] o_gamma;
    logic [31:0] o_t;
    logic        o_hit;
    logic        o_degen;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 i_clk = ~i_clk;

    fip_32_cramer_solve dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_det_a(i_det_a),
        .i_det_b(i_det_b),
        .i_det_g(i_det_g),
        .i_det_t(i_det_t),
        .i_tmax (i_tmax),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_beta (o_beta),
        .o_gamma(o_gamma),
        .o_t    (o_t),
        .o_hit  (o_hit),
        .o_degen(o_degen)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one set and count cycles from the accepting edge until o_valid.
    task automatic launch(input logic [31:0] a, b, g, t, tmax, output int cycles);
        @(negedge i_clk);
        i_det_a = a;
        i_det_b = b;
        i_det_g = g;
        i_det_t = t;
        i_tmax  = tmax;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        cycles = 0;
        while (!o_valid && cycles < 200) begin
            @(posedge i_clk);
            #1;
            cycles++;
        end
    endtask

    task automatic expect_res(input string tag, input logic [31:0] beta, gamma, t,
                              input logic hit, degen, input int cycles);
        check({tag, "_lat"}, 32'(cycles), 32'd50);
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, "_beta"}, o_beta, beta);
        check({tag, "_gamma"}, o_gamma, gamma);
        check({tag, "_t"}, o_t, t);
        check({tag, "_hit"}, {31'd0, o_hit}, {31'd0, hit});
        check({tag, "_degen"}, {31'd0, o_degen}, {31'd0, degen});
    endtask

    task automatic release_result(input string tag);
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check({tag, "_idle_ready"}, {31'd0, o_ready}, 32'd1);
        check({tag, "_idle_valid"}, {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        #2;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_beta", o_beta, 32'd0);
        check("rst_hit", {31'd0, o_hit}, 32'd0);
        check("rst_degen", {31'd0, o_degen}, 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);
        check("rst_ready", {31'd0, o_ready}, 32'd1);

        launch(32'h00010000, 32'h00004000, 32'h00004000, 32'h00020000, 32'h00100000, lat);
        expect_res("basic", 32'h00004000, 32'h00004000, 32'h00020000, 1'b1, 1'b0, lat);
        release_result("basic");

        launch(32'hFFFE0000, 32'hFFFF8000, 32'h00010000, 32'hFFFC0000, 32'h00100000, lat);
        expect_res("signs", 32'h00004000, 32'hFFFF8000, 32'h00020000, 1'b0, 1'b0, lat);
        release_result("signs");

        // 1/3 and -1/3 must truncate toward zero.
        launch(32'h00030000, 32'h00010000, 32'hFFFF0000, 32'h00030000, 32'h00100000, lat);
        expect_res("trunc", 32'h00005555, 32'hFFFFAAAB, 32'h00010000, 1'b0, 1'b0, lat);
        release_result("trunc");

        launch(32'h00000000, 32'h00001234, 32'h00005678, 32'h00010000, 32'h00100000, lat);
        expect_res("degen", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, lat);
        release_result("degen");

        launch(32'h00000001, 32'hFFFF0000, 32'h00000000, 32'h00010000, 32'h7FFFFFFF, lat);
        expect_res("sat", 32'h80000000, 32'h0, 32'h7FFFFFFF, 1'b0, 1'b0, lat);
        release_result("sat");

        launch(32'h00010000, 32'h00008000, 32'h00008000, 32'h00000042, 32'h00100000, lat);
        expect_res("tmin_p1", 32'h00008000, 32'h00008000, 32'h00000042, 1'b1, 1'b0, lat);
        release_result("tmin_p1");

        launch(32'h00010000, 32'h00008000, 32'h00008000, 32'h00000041, 32'h00100000, lat);
        expect_res("tmin_eq", 32'h00008000, 32'h00008000, 32'h00000041, 1'b0, 1'b0, lat);
        release_result("tmin_eq");

        launch(32'h00010000, 32'h00008000, 32'h00008000, 32'h00020000, 32'h00020000, lat);
        expect_res("tmax_eq", 32'h00008000, 32'h00008000, 32'h00020000, 1'b0, 1'b0, lat);
        release_result("tmax_eq");

        launch(32'h00010000, 32'h00008001, 32'h00008000, 32'h00020000, 32'h00100000, lat);
        expect_res("sum_over", 32'h00008001, 32'h00008000, 32'h00020000, 1'b0, 1'b0, lat);
        release_result("sum_over");

        // Backpressure: result held, new set offered during DONE must be dropped.
        launch(32'h00010000, 32'h00004000, 32'h00004000, 32'h00020000, 32'h00100000, lat);
        expect_res("bp", 32'h00004000, 32'h00004000, 32'h00020000, 1'b1, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (i == 3) begin
                i_det_b = 32'h00002000;
                i_det_g = 32'h00006000;
                i_det_t = 32'h00030000;
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            @(posedge i_clk);
            #1;
            check("bp_ready", {31'd0, o_ready}, 32'd0);
            check("bp_valid", {31'd0, o_valid}, 32'd1);
            check("bp_beta", o_beta, 32'h00004000);
            check("bp_t", o_t, 32'h00020000);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        release_result("bp");
        repeat (3) begin
            @(posedge i_clk);
            #1;
            check("bp_no_accept", {31'd0, o_ready}, 32'd1);
        end
        launch(32'h00010000, 32'h00002000, 32'h00006000, 32'h00030000, 32'h00100000, lat);
        expect_res("bp_new", 32'h00002000, 32'h00006000, 32'h00030000, 1'b1, 1'b0, lat);
        release_result("bp_new");

        // Reset 20 cycles into the division aborts it and clears the outputs at once.
        @(negedge i_clk);
        i_det_a = 32'h00010000;
        i_det_b = 32'h00004000;
        i_det_g = 32'h00004000;
        i_det_t = 32'h00020000;
        i_tmax  = 32'h00100000;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (20) @(posedge i_clk);
        #2;
        i_rstn = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_beta", o_beta, 32'd0);
        check("mid_rst_gamma", o_gamma, 32'd0);
        check("mid_rst_t", o_t, 32'd0);
        check("mid_rst_hit", {31'd0, o_hit}, 32'd0);
        check("mid_rst_degen", {31'd0, o_degen}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
        repeat (60) begin
            @(posedge i_clk);
            #1;
            check("post_rst_quiet", {31'd0, o_valid}, 32'd0);
        end
        launch(32'hFFFE0000, 32'hFFFF8000, 32'h00010000, 32'hFFFC0000, 32'h00100000, lat);
        expect_res("post_rst", 32'h00004000, 32'hFFFF8000, 32'h00020000, 1'b0, 1'b0, lat);
        release_result("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fip_32_cramer_solve.md
Name: fip_32_cramer_solve

Overview:
- Downstream consumer of the 3x3 determinant pipeline in the ray-triangle intersection path.
- Takes the system determinant detA and the three column-substituted determinants detB, detG and detT, all in Q16.16.
- Computes beta = detB/detA, gamma = detG/detA and t = detT/detA using three parallel bit-serial dividers.
- Emits the barycentrics, t and a hit flag through a valid/ready handshake.

Parameters:
- FRA_BITS, 16: number of fractional bits in every operand and result.
- T_MIN, 32'sh00000041: exclusive lower bound on t for a hit (about 0.001).
- DET_EPS, 32'sh00000001: if |detA| < DET_EPS the system is degenerate.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_valid  in  1  upstream determinants are valid.
- o_ready  out  1  block can accept a new set.
- i_det_a  in  32  detA, signed Q16.16.
- i_det_b  in  32  detB, signed Q16.16.
- i_det_g  in  32  detG, signed Q16.16.
- i_det_t  in  32  detT, signed Q16.16.
- i_tmax  in  32  exclusive upper bound on t, signed; sampled on accept.
- o_valid  out  1  result is valid.
- i_ready  in  1  downstream accepts the result.
- o_beta  out  32  signed Q16.16.
- o_gamma  out  32  signed Q16.16.
- o_t  out  32  signed Q16.16.
- o_hit  out  1  intersection test passed.
- o_degen  out  1  detA was degenerate.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (i_rstn). Asserting it clears state to IDLE and sets o_valid=0, o_beta=o_gamma=o_t=0, o_hit=0, o_degen=0.
- Reset mid-operation: the operation in flight is aborted and no result is produced.
- FSM states: IDLE, DIV, FIN, DONE.
  - IDLE: o_ready=1. On i_valid & o_ready, capture all inputs and go to DIV with iteration counter = 47.
  - DIV: one restoring-division step per cycle in each of the three dividers; the counter decrements. When the counter reaches 0, go to FIN.
  - FIN: apply sign, saturation and the hit test; register the outputs; go to DONE.
  - DONE: o_valid=1; outputs stay frozen until i_ready=1, then go to IDLE.
- Latency: o_valid rises exactly 50 cycles after the accepting edge. Throughput is one result per at least 51 cycles.
- No bypass: o_ready=0 in every state except IDLE, including the DONE cycle in which i_ready=1.
- i_valid outside IDLE is ignored. Upstream must hold its data or drop it; the block never buffers it.
- Division, per quotient:
  - Dividend = |num| << FRA_BITS as a 48-bit unsigned value; divisor = |detA| as 32-bit unsigned.
  - 48-iteration restoring algorithm producing a 48-bit unsigned quotient.
  - Magnitude of 0x80000000 (-2^31) is computed in 33 bits so no wrap occurs.
  - Result sign = sign(num) XOR sign(detA); the quotient truncates toward zero.
- Saturation:
  - Positive quotient > 0x7FFFFFFF → 0x7FFFFFFF.
  - Negative magnitude > 0x80000000 → 0x80000000.
- Degenerate case (|detA| < DET_EPS, including detA = 0):
  - Dividers still run, so latency stays fixed.
  - Outputs forced: o_beta=o_gamma=o_t=0, o_hit=0, o_degen=1.
- Hit test (all terms must hold; otherwise o_hit=0):
  - beta ≥ 0 and gamma ≥ 0.
  - beta + gamma ≤ 0x00010000, evaluated as a 33-bit sum.
  - t > T_MIN and t < i_tmax (the captured value).
  - not degenerate.
- Boundaries:
  - beta + gamma exactly equal to 1.0 counts as a hit.
  - t exactly equal to T_MIN or to i_tmax is a miss.
  - Saturated values take part in the comparisons as their saturated values.

Decomposition:
- Shared package fip_pkg holds:
  - FRA_BITS default, FIP_MIN, FIP_MAX, FIP_ONE = 32'sh00010000.
  - fip_t typedef: logic signed [31:0].
  - FSM state enum for this block.
- Sub-module fip_32_div_iter:
  - Ports: start, numerator, denominator in; quotient out, with sign handling and saturation.
  - Instantiated three times, all started from the shared FSM.
  - Holds its own 48-bit quotient/remainder shift registers; shares the FSM's counter.

Test Plan:
1. Basic hit: detA=0x00010000, detB=0x00004000, detG=0x00004000, detT=0x00020000, i_tmax=0x00100000, i_ready=1 → o_valid 50 cycles after accept; o_beta=0x00004000, o_gamma=0x00004000, o_t=0x00020000, o_hit=1, o_degen=0.
2. Signs: detA=0xFFFE0000 (-2.0), detB=0xFFFF8000 (-0.5), detG=0x00010000, detT=0xFFFC0000, i_tmax=0x00100000 → o_beta=0x00004000, o_gamma=0xFFFF8000, o_t=0x00020000, o_hit=0.
3. Degenerate and saturation:
   - detA=0, others arbitrary → all outputs 0, o_degen=1, o_hit=0, still 50-cycle latency.
   - detA=0x00000001, detT=0x00010000 → o_t=0x7FFFFFFF; o_hit=0 for i_tmax=0x7FFFFFFF.
4. Edge equality: detA=0x00010000, detB=0x00008000, detG=0x00008000, detT=T_MIN+1 → o_hit=1. Repeat with detT=T_MIN → o_hit=0.
5. Backpressure: hold i_ready=0 for 10 cycles after o_valid → outputs stable and o_ready=0. Pulse i_valid with new data meanwhile → ignored. Raise i_ready → IDLE next cycle; the new set is accepted only afterwards.
6. Reset mid-DIV: deassert i_rstn 20 cycles after accept → o_valid=0 and all outputs 0 immediately. After release, a new accept completes in exactly 50 cycles with correct results.
